bcd_updown_timer: RTL and testbench

//  Parametrised up/down counter and countdown timer for the board's seven-segment display path.

---
 rtl/bcd_updown_timer_if.sv | 24 ++
 rtl/bcd_updown_timer.sv | 173 +++++++++++++++++
 tb/tb_bcd_updown_timer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_updown_timer_if.sv
// Button/preset inputs and display-side outputs of the up/down BCD timer, grouped as one bundle.
// The master drives the buttons and preset word; the slave (the timer) drives count and status.
interface bcd_updown_timer_if #(
  parameter int DIGITS = 4
);
  logic [3:0]          i_btn;
  logic [4*DIGITS-1:0] i_preset;
  logic [4*DIGITS-1:0] o_count;
  logic                o_down;
  logic                o_running;
  logic                o_expired;
  logic                o_blink;
  logic                o_tick;

  modport master (
    output i_btn, i_preset,
    input  o_count, o_down, o_running, o_expired, o_blink, o_tick
  );

  modport slave (
    input  i_btn, i_preset,
    output o_count, o_down, o_running, o_expired, o_blink, o_tick
  );
endinterface

// File: rtl/bcd_updown_timer.sv
// Up/down BCD/hex counter and countdown timer fed by debounced push-buttons for the 7-segment path.
// Button action lands 2+DEB_CYCLES+1 cycles after the raw edge; no backpressure, outputs are always valid.
module bcd_updown_timer #(
  parameter int DIGITS     = 4,
  parameter int BCD        = 1,
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  bcd_updown_timer_if.slave     io_tmr
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  localparam logic [3:0]    MAXD   = (BCD != 0) ? 4'd9 : 4'd15;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
  localparam logic [CW-1:0] D_LAST = CW'(DEB_CYCLES - 1);

  localparam int B_CLR  = 0;
  localparam int B_LOAD = 1;
  localparam int B_TGL  = 2;
  localparam int B_RUN  = 3;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb_lvl;
  logic [CW-1:0] r_deb_cnt [4];
  logic [3:0]    r_press;

  logic [W-1:0]  r_count;
  logic          r_down;
  logic          r_running;
  logic          r_expired;
  logic [PW-1:0] r_presc;

  logic [W-1:0]  w_inc;
  logic [W-1:0]  w_dec;
  logic          w_carry;
  logic          w_borrow;
  logic [W-1:0]  w_load_val;
  logic          w_zero;
  logic          w_dec_zero;
  logic          w_presc_last;
  logic          w_tick;
  logic [PW-1:0] w_presc_nxt;

  // Synchroniser and debouncer; r_press pulses in the cycle after the level has risen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb_lvl <= '0;
      r_press   <= '0;
      for (int b = 0; b < 4; b++) begin
        r_deb_cnt[b] <= '0;
      end
    end else begin
      r_sync1 <= io_tmr.i_btn;
      r_sync2 <= r_sync1;
      for (int b = 0; b < 4; b++) begin
        r_press[b] <= 1'b0;
        if (r_sync2[b] == r_deb_lvl[b]) begin
          r_deb_cnt[b] <= '0;
        end else if (r_deb_cnt[b] == D_LAST) begin
          r_deb_lvl[b] <= r_sync2[b];
          r_deb_cnt[b] <= '0;
          r_press[b]   <= r_sync2[b];
        end else begin
          r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Ripple carry/borrow across digits, each digit wrapping at MAXD.
  always_comb begin
    w_inc    = r_count;
    w_dec    = r_count;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_carry) begin
        if (r_count[4*d +: 4] == MAXD) begin
          w_inc[4*d +: 4] = 4'd0;
        end else begin
          w_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
          w_carry         = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_count[4*d +: 4] == 4'd0) begin
          w_dec[4*d +: 4] = MAXD;
        end else begin
          w_dec[4*d +: 4] = r_count[4*d +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_load_val = io_tmr.i_preset;
    if (BCD != 0) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (io_tmr.i_preset[4*d +: 4] > 4'd9) begin
          w_load_val[4*d +: 4] = 4'd9;
        end
      end
    end
  end

  assign w_zero       = (r_count == '0);
  assign w_dec_zero   = (w_dec == '0);
  assign w_presc_last = (r_presc == P_LAST);
  assign w_tick       = r_running & w_presc_last;
  assign w_presc_nxt  = !r_running  ? r_presc :
                        w_presc_last ? '0 : r_presc + 1'b1;

  // Only the highest-priority press acts; any press swallows a coincident tick step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= '0;
      r_down    <= 1'b0;
      r_running <= 1'b0;
      r_expired <= 1'b0;
      r_presc   <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      if (r_press[B_CLR]) begin
        r_count   <= '0;
        r_running <= 1'b0;
        r_expired <= 1'b0;
        r_presc   <= '0;
      end else if (r_press[B_LOAD]) begin
        r_count   <= w_load_val;
        r_expired <= 1'b0;
        r_presc   <= '0;
      end else if (r_press[B_TGL]) begin
        r_down    <= ~r_down;
        r_expired <= 1'b0;
      end else if (r_press[B_RUN]) begin
        if (r_running) begin
          r_running <= 1'b0;
        end else if (!(r_down && w_zero)) begin
          r_running <= 1'b1;
          r_presc   <= '0;
        end
      end else if (w_tick) begin
        if (!r_down) begin
          r_count <= w_inc;
        end else if (!w_zero) begin
          r_count <= w_dec;
          if (w_dec_zero) begin
            r_expired <= 1'b1;
            r_running <= 1'b0;
          end
        end
      end
    end
  end

  assign io_tmr.o_count   = r_count;
  assign io_tmr.o_down    = r_down;
  assign io_tmr.o_running = r_running;
  assign io_tmr.o_expired = r_expired;
  assign io_tmr.o_tick    = w_tick;
  assign io_tmr.o_blink   = r_running & (r_presc < P_HALF);

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Bench for bcd_updown_timer: a BCD instance and a hex instance, 2 digits, TICK_DIV=10, DEB_CYCLES=4.
module tb_bcd_updown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_updown_timer_if #(.DIGITS(2)) bus_b ();
  bcd_updown_timer_if #(.DIGITS(2)) bus_h ();

  bcd_updown_timer #(.DIGITS(2), .BCD(1), .TICK_DIV(10), .DEB_CYCLES(4)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .io_tmr(bus_b)
  );

  bcd_updown_timer #(.DIGITS(2), .BCD(0), .TICK_DIV(10), .DEB_CYCLES(4)) dut_h (
    .i_clk (clk),
    .i_rst (rst),
    .io_tmr(bus_h)
  );

  typedef struct packed {
    logic [3:0] btn;
    logic [7:0] preset;
    logic [7:0] cnt;
    logic       dn;
    logic       run;
    logic       xp;
  } vec_t;

  vec_t tbl [13];
  vec_t sb_q [$];
  vec_t e;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;
  int blinks = 0;
  int first_tick = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic drive(input int sel, input logic [3:0] b, input logic [7:0] p);
    if (sel == 0) begin
      bus_b.i_btn = b; bus_b.i_preset = p;
    end else begin
      bus_h.i_btn = b; bus_h.i_preset = p;
    end
  endtask

  // Raw edge now; action registers on the 7th rising edge; sample just after it.
  task automatic press(input int sel, input logic [3:0] b, input logic [7:0] p);
    drive(sel, b, p);
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic release_btn(input int sel);
    if (sel == 0) bus_b.i_btn = 4'b0000;
    else          bus_h.i_btn = 4'b0000;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int sel, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if ((sel == 0 ? bus_b.o_tick : bus_h.o_tick) === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk({nm, "_tick_seen"}, {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0010, 8'h3C, 8'h39, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 8'h45, 8'h45, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0100, 8'h00, 8'h45, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{4'b0100, 8'h00, 8'h45, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0001, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0010, 8'hA7, 8'h97, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0010, 8'h9A, 8'h99, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0011, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b1100, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{4'b1000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{4'b0110, 8'h12, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{4'b0001, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{4'b0100, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    drive(0, 4'b0000, 8'h00);
    drive(1, 4'b0000, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", {24'd0, bus_b.o_count}, 32'h00);
    chk("rst_flags", {28'd0, bus_b.o_down, bus_b.o_running, bus_b.o_expired, bus_b.o_blink}, 32'h0);
    chk("rst_tick", {31'd0, bus_b.o_tick}, 32'h0);
    chk("rst_hex_count", {24'd0, bus_h.o_count}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Free-running up count from 00 for 100 cycles.
    press(0, 4'b1000, 8'h00);
    chk("t1_running", {31'd0, bus_b.o_running}, 32'd1);
    bus_b.i_btn = 4'b0000;
    for (int k = 0; k <= 100; k++) begin
      if (k % 10 == 0) chk("t1_count", {24'd0, bus_b.o_count}, {24'd0, bcd2(k / 10)});
      if (k < 100) begin
        if (bus_b.o_tick === 1'b1) begin
          ticks++;
          if (first_tick < 0) first_tick = k;
        end
        if (bus_b.o_blink === 1'b1) blinks++;
        @(posedge clk);
        #1;
      end
    end
    chk("t1_ticks", ticks, 32'd10);
    chk("t1_blinks", blinks, 32'd50);
    chk("t1_first_tick", first_tick, 32'd9);
    press(0, 4'b1000, 8'h00);
    chk("t1_stop", {23'd0, bus_b.o_count, bus_b.o_running}, {23'd0, 8'h10, 1'b0});
    chk("t1_stop_blink", {30'd0, bus_b.o_blink, bus_b.o_tick}, 32'd0);
    release_btn(0);

    // Table of single-press and coincident-press actions while stopped.
    for (int i = 0; i < 13; i++) begin
      drive(0, tbl[i].btn, tbl[i].preset);
      sb_q.push_back(tbl[i]);
      repeat (7) @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("tbl%0d_count", i), {24'd0, bus_b.o_count}, {24'd0, e.cnt});
      chk($sformatf("tbl%0d_flags", i), {29'd0, bus_b.o_down, bus_b.o_running, bus_b.o_expired},
          {29'd0, e.dn, e.run, e.xp});
      release_btn(0);
    end

    // Up wrap at all-max, BCD then hex.
    press(0, 4'b0010, 8'h99);
    chk("t2_load", {24'd0, bus_b.o_count}, 32'h99);
    release_btn(0);
    press(0, 4'b1000, 8'h00);
    bus_b.i_btn = 4'b0000;
    wait_step(0, "t2");
    chk("t2_wrap", {23'd0, bus_b.o_count, bus_b.o_expired}, {23'd0, 8'h00, 1'b0});
    press(0, 4'b0001, 8'h00);
    release_btn(0);
    press(1, 4'b0010, 8'hFF);
    chk("t2h_load", {24'd0, bus_h.o_count}, 32'hFF);
    release_btn(1);
    press(1, 4'b1000, 8'h00);
    bus_h.i_btn = 4'b0000;
    wait_step(1, "t2h");
    chk("t2h_wrap", {23'd0, bus_h.o_count, bus_h.o_expired}, {23'd0, 8'h00, 1'b0});

    // Countdown from 03 to expiry, then a refused run start.
    press(0, 4'b0010, 8'h03);
    release_btn(0);
    press(0, 4'b0100, 8'h00);
    release_btn(0);
    press(0, 4'b1000, 8'h00);
    bus_b.i_btn = 4'b0000;
    chk("t3_start", {30'd0, bus_b.o_down, bus_b.o_running}, 32'b11);
    wait_step(0, "t3a");
    chk("t3_02", {24'd0, bus_b.o_count}, 32'h02);
    wait_step(0, "t3b");
    chk("t3_01", {24'd0, bus_b.o_count}, 32'h01);
    wait_step(0, "t3c");
    chk("t3_00", {21'd0, bus_b.o_count, bus_b.o_down, bus_b.o_running, bus_b.o_expired},
        {21'd0, 8'h00, 1'b1, 1'b0, 1'b1});
    repeat (8) @(posedge clk);
    #1;
    press(0, 4'b1000, 8'h00);
    chk("t3_rerun", {22'd0, bus_b.o_count, bus_b.o_running, bus_b.o_expired}, {22'd0, 8'h00, 1'b0, 1'b1});
    release_btn(0);
    press(0, 4'b0100, 8'h00);
    chk("t3_tgl", {30'd0, bus_b.o_down, bus_b.o_expired}, 32'd0);
    release_btn(0);

    // Bouncing run button, then a steady hold: one toggle, 7 edges after the last rise.
    for (int i = 0; i < 10; i++) begin
      drive(0, (i % 2 == 0) ? 4'b1000 : 4'b0000, 8'h00);
      repeat (2) @(posedge clk);
      #1;
    end
    chk("t4_bounce", {31'd0, bus_b.o_running}, 32'd0);
    drive(0, 4'b1000, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    chk("t4_early", {31'd0, bus_b.o_running}, 32'd0);
    @(posedge clk);
    #1;
    chk("t4_edge", {31'd0, bus_b.o_running}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("t4_hold", {31'd0, bus_b.o_running}, 32'd1);
    release_btn(0);
    chk("t4_release", {31'd0, bus_b.o_running}, 32'd1);

    // Asynchronous reset while running at 57.
    press(0, 4'b0001, 8'h00);
    release_btn(0);
    press(0, 4'b0010, 8'h57);
    release_btn(0);
    press(0, 4'b1000, 8'h00);
    bus_b.i_btn = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre", {23'd0, bus_b.o_count, bus_b.o_running}, {23'd0, 8'h57, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("t6_count", {24'd0, bus_b.o_count}, 32'h00);
    chk("t6_flags", {27'd0, bus_b.o_down, bus_b.o_running, bus_b.o_expired, bus_b.o_blink, bus_b.o_tick},
        32'd0);
    chk("t6_hex", {23'd0, bus_h.o_count, bus_h.o_running}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
